// File: rtl/aes_uart_pkg.sv
// Constants shared by the AES core's UART transmit and receive paths.
// The tx FSM encoding lives here so the rx side and debug tooling decode it the same way.
package aes_uart_pkg;

  localparam int BLOCK_BYTES          = 16;
  localparam int FRAME_BITS           = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 864;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Free-running bit-period counter: tick marks the last cycle of each bit period.
// clear restarts the period so bit boundaries align to the accepting edge.
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 864
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_block128.sv
// Serializes one 128-bit block as 16 8N1 frames, most-significant byte first.
// Handshake: start is accepted on any edge where busy==0; busy stays high until done pulses.
module uart_tx_block128
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int GAP_BITS     = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] din,
  output logic         busy,
  output logic         done,
  output logic         tx
);

  localparam logic [3:0] LAST_BYTE = 4'(BLOCK_BYTES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_BITS - 1);

  logic [2:0]   state;
  logic [127:0] shift_reg;
  logic [3:0]   byte_cnt;
  logic [2:0]   bit_idx;
  logic [3:0]   gap_cnt;
  logic         tick;
  logic         accept;
  logic [7:0]   cur_byte;
  logic [2:0]   bit_nxt;

  // busy is low only in IDLE and DONE, so this covers the back-to-back case.
  assign accept   = start && !busy;
  assign cur_byte = shift_reg[127:120];
  assign bit_nxt  = bit_idx + 3'd1;

  uart_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      byte_cnt  <= '0;
      bit_idx   <= '0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tx        <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
          if (start) begin
            shift_reg <= din;
            byte_cnt  <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b1;
            tx        <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx      <= cur_byte[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_nxt;
              tx      <= cur_byte[bit_nxt];
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (byte_cnt == LAST_BYTE) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              tx    <= 1'b1;
            end else begin
              shift_reg <= {shift_reg[119:0], 8'h00};
              byte_cnt  <= byte_cnt + 4'd1;
              gap_cnt   <= '0;
              if (GAP_BITS > 0) begin
                state <= ST_GAP;
                tx    <= 1'b1;
              end else begin
                state <= ST_START;
                tx    <= 1'b0;
              end
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_block128.sv
// Bench for uart_tx_block128: three parameterisations share one tx decoder via a select mux.
// Decoded bytes are matched against a queue filled when each block is driven.
module tb_uart_tx_block128;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] din;
  logic [1:0]   sel;
  logic         mon_en;

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;
  logic tx_c, busy_c, done_c;
  logic tx_m, busy_m, done_m;
  int   cur_cpb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int lat;
  int dcyc;
  int done_seen;
  int busy_cycles;

  logic [7:0] exp_q[$];

  localparam logic [127:0] K1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] K2 = 128'h6bc1bee22e409f96e93d7e117393172a;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_block128 #(.CLKS_PER_BIT(4), .GAP_BITS(0)) u_a (
    .clk(clk), .reset(reset), .start(start && (sel == 2'd0)), .din(din),
    .busy(busy_a), .done(done_a), .tx(tx_a)
  );
  uart_tx_block128 #(.CLKS_PER_BIT(4), .GAP_BITS(2)) u_b (
    .clk(clk), .reset(reset), .start(start && (sel == 2'd1)), .din(din),
    .busy(busy_b), .done(done_b), .tx(tx_b)
  );
  uart_tx_block128 #(.CLKS_PER_BIT(864), .GAP_BITS(0)) u_c (
    .clk(clk), .reset(reset), .start(start && (sel == 2'd2)), .din(din),
    .busy(busy_c), .done(done_c), .tx(tx_c)
  );

  always_comb begin
    tx_m    = tx_a;
    busy_m  = busy_a;
    done_m  = done_a;
    cur_cpb = 4;
    case (sel)
      2'd1: begin tx_m = tx_b; busy_m = busy_b; done_m = done_b; end
      2'd2: begin tx_m = tx_c; busy_m = busy_c; done_m = done_c; cur_cpb = 864; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic push_block(input logic [127:0] b);
    for (int k = 0; k < 16; k++) exp_q.push_back(b[127-8*k -: 8]);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [127:0] b);
    start       = 1'b1;
    din         = b;
    busy_cycles = 0;
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_done(input int budget, output int latency);
    int n;
    n = 0;
    while (!done_m && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_m) check("done_timeout", done_m, 1);
    latency = cyc - t0;
  endtask

  // scoreboard side: sampling decoder at mid-bit, plus done/busy observation
  logic       in_frame = 1'b0;
  logic       prev_tx  = 1'b1;
  logic       prev_done = 1'b0;
  int         mcnt;
  int         bi;
  logic [7:0] bits;

  always @(negedge clk) begin
    if (!mon_en) begin
      in_frame = 1'b0;
      prev_tx  = 1'b1;
    end else begin
      if (!in_frame) begin
        if (prev_tx && !tx_m) begin
          in_frame = 1'b1;
          mcnt     = 0;
          bits     = '0;
        end
      end else begin
        mcnt++;
        if (tx_m !== prev_tx) check("edge_align", mcnt % cur_cpb, 0);
      end
      if (in_frame && (mcnt % cur_cpb) == cur_cpb / 2) begin
        bi = mcnt / cur_cpb;
        if (bi == 0) begin
          check("start_bit", tx_m, 0);
        end else if (bi <= 8) begin
          bits[bi-1] = tx_m;
        end else begin
          check("stop_bit", tx_m, 1);
          if (exp_q.size() == 0) check("sb_unexpected_byte", bits, 128'h100);
          else check("byte", bits, exp_q.pop_front());
          in_frame = 1'b0;
        end
      end
      prev_tx = tx_m;
    end
    if (busy_m) busy_cycles++;
    if (done_m) begin
      done_seen++;
      check("done_width", prev_done, 0);
    end
    prev_done = done_m;
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    din       = '0;
    sel       = 2'd0;
    mon_en    = 1'b0;
    done_seen = 0;
    busy_cycles = 0;

    // reset state
    tick_n(5);
    reset = 1'b0;
    tick_n(2);
    check("rst_tx_a", tx_a, 1);   check("rst_busy_a", busy_a, 0); check("rst_done_a", done_a, 0);
    check("rst_tx_b", tx_b, 1);   check("rst_busy_b", busy_b, 0); check("rst_done_b", done_b, 0);
    check("rst_tx_c", tx_c, 1);   check("rst_busy_c", busy_c, 0); check("rst_done_c", done_c, 0);
    mon_en = 1'b1;

    // basic block, no gap
    push_block(K1);
    send(K1);
    check("busy_rise", busy_m, 1);
    check("tx_start_edge", tx_m, 0);
    wait_done(800, lat);
    check("done_lat", lat, 640);
    check("busy_len", busy_cycles, 640);
    check("busy_at_done", busy_m, 0);
    check("sb_drain_a", exp_q.size(), 0);
    tick_n(3);

    // gap of two idle bits between frames
    sel = 2'd1;
    tick_n(2);
    push_block(K1);
    send(K1);
    wait_done(900, lat);
    check("done_lat_gap", lat, 760);
    check("busy_len_gap", busy_cycles, 760);
    check("sb_drain_b", exp_q.size(), 0);
    tick_n(3);

    // start while busy is ignored
    sel = 2'd0;
    tick_n(2);
    push_block(K1);
    send(K1);
    tick_n(99);
    start = 1'b1;
    din   = K2;
    @(negedge clk);
    start = 1'b0;
    wait_done(800, lat);
    check("done_lat_ign", lat, 640);
    check("sb_drain_ign", exp_q.size(), 0);
    tick_n(3);

    // start held high: back-to-back blocks
    start = 1'b1;
    din   = '1;
    push_block('1);
    busy_cycles = 0;
    @(negedge clk);
    t0 = cyc;
    check("b2b_busy0", busy_m, 1);
    tick_n(5);
    din = '0;
    push_block('0);
    wait_done(800, lat);
    check("b2b_lat1", lat, 640);
    check("b2b_idle_tx", tx_m, 1);
    dcyc = cyc;
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
    check("b2b_busy1", busy_m, 1);
    check("b2b_tx_start", tx_m, 0);
    wait_done(800, lat);
    check("b2b_lat2", lat, 640);
    check("b2b_lat_total", cyc - dcyc, 641);
    check("sb_drain_b2b", exp_q.size(), 0);
    tick_n(3);

    // reset in the middle of the first data bit (0 for byte 3a)
    push_block(K1);
    send(K1);
    tick_n(5);
    check("pre_rst_tx", tx_m, 0);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_tx", tx_m, 1);
    check("async_rst_busy", busy_m, 0);
    mon_en = 1'b0;
    exp_q.delete();
    done_seen = 0;
    tick_n(2);
    reset = 1'b0;
    tick_n(700);
    check("rst_no_done", done_seen, 0);
    check("rst_idle_tx", tx_m, 1);

    // full-rate timing: first two frames of a block at 864 clocks per bit
    sel = 2'd2;
    tick_n(2);
    mon_en = 1'b1;
    exp_q.push_back(K2[127:120]);
    exp_q.push_back(K2[119:112]);
    send(K2);
    tick_n(2 * 10 * 864 + 100);
    check("sb_drain_864", exp_q.size(), 0);
    check("busy_864", busy_m, 1);
    mon_en = 1'b0;
    reset  = 1'b1;
    tick_n(2);
    reset = 1'b0;
    tick_n(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
